// File: rtl/imsic_setipnum_arbiter.sv
// Round-robin arbiter feeding a small FIFO that replays accepted MSI writes
// as one-cycle, one-hot setipnum strobes into the IMSIC interrupt files.
module imsic_setipnum_arbiter #(
    parameter int NrReq       = 2,
    parameter int NrHarts     = 4,
    parameter int NrInptFiles = 3,
    parameter int NrSourcesW  = 6,
    parameter int FifoDepth   = 4,
    localparam int HartW      = (NrHarts > 1) ? $clog2(NrHarts) : 1,
    localparam int FileW      = (NrInptFiles > 1) ? $clog2(NrInptFiles) : 1,
    localparam int NrFiles    = NrHarts * NrInptFiles
) (
    input  logic                          i_clk,
    input  logic                          ni_rst,
    input  logic [NrReq-1:0]              i_req_valid,
    output logic [NrReq-1:0]              o_req_ready,
    input  logic [NrReq*HartW-1:0]        i_req_hart,
    input  logic [NrReq*FileW-1:0]        i_req_file,
    input  logic [NrReq*NrSourcesW-1:0]   i_req_ipnum,
    input  logic                          i_stall,
    output logic [NrFiles*NrSourcesW-1:0] o_setipnum,
    output logic [NrFiles-1:0]            o_setipnum_we,
    output logic [15:0]                   o_drop_cnt,
    output logic                          o_busy
);

    localparam int RrW  = $clog2(NrReq);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam int EntW = HartW + FileW + NrSourcesW;

    logic [RrW-1:0]                  rr_q, rr_d;
    logic [PtrW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]                 count_q, count_d;
    logic [15:0]                     drop_q, drop_d;
    logic [NrFiles-1:0]              we_q, we_d;
    logic [NrFiles*NrSourcesW-1:0]   setip_q, setip_d;
    logic [EntW-1:0]                 mem_q [FifoDepth];

    logic [NrReq-1:0]      grant;
    logic [RrW-1:0]        gnt_idx;
    logic                  gnt_any;
    logic [HartW-1:0]      sel_hart;
    logic [FileW-1:0]      sel_file;
    logic [NrSourcesW-1:0] sel_ipnum;
    logic                  malformed;
    logic                  push;
    logic                  pop;
    logic [EntW-1:0]       head;
    logic [HartW-1:0]      head_hart;
    logic [FileW-1:0]      head_file;
    logic [NrSourcesW-1:0] head_ipnum;

    // Grant is gated only by FIFO occupancy, never by stall or a same-cycle pop.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (count_q < CntW'(FifoDepth)) begin
            for (int k = 0; k < NrReq; k++) begin
                for (int r = 0; r < NrReq; r++) begin
                    if (!gnt_any && i_req_valid[r] &&
                        r == ((int'(rr_q) + k) % NrReq)) begin
                        gnt_any  = 1'b1;
                        gnt_idx  = RrW'(r);
                        grant[r] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_hart  = '0;
        sel_file  = '0;
        sel_ipnum = '0;
        for (int r = 0; r < NrReq; r++) begin
            if (r == int'(gnt_idx)) begin
                sel_hart  = i_req_hart[r*HartW +: HartW];
                sel_file  = i_req_file[r*FileW +: FileW];
                sel_ipnum = i_req_ipnum[r*NrSourcesW +: NrSourcesW];
            end
        end
    end

    assign malformed = (sel_ipnum == '0) ||
                       (int'(sel_hart) >= NrHarts) ||
                       (int'(sel_file) >= NrInptFiles);

    assign push = gnt_any && !malformed;
    assign pop  = (count_q != '0) && !i_stall;

    assign head       = mem_q[rd_ptr_q];
    assign head_ipnum = head[NrSourcesW-1:0];
    assign head_file  = head[NrSourcesW +: FileW];
    assign head_hart  = head[NrSourcesW+FileW +: HartW];

    always_comb begin
        rr_d = rr_q;
        if (gnt_any) begin
            if (int'(gnt_idx) == NrReq - 1) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_idx + 1'b1;
            end
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (gnt_any && malformed && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_comb begin
        we_d    = '0;
        setip_d = '0;
        for (int f = 0; f < NrFiles; f++) begin
            if (pop && f == int'(head_hart) * NrInptFiles + int'(head_file)) begin
                we_d[f]                           = 1'b1;
                setip_d[f*NrSourcesW +: NrSourcesW] = head_ipnum;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sel_hart, sel_file, sel_ipnum};
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            we_q     <= '0;
            setip_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            we_q     <= we_d;
            setip_q  <= setip_d;
        end
    end

    assign o_req_ready   = grant;
    assign o_setipnum    = setip_q;
    assign o_setipnum_we = we_q;
    assign o_drop_cnt    = drop_q;
    assign o_busy        = (count_q != '0) || (we_q != '0);

endmodule

// File: tb/tb_imsic_setipnum_arbiter.sv
// Bench for imsic_setipnum_arbiter: directed scenarios plus random traffic,
// compared against a queue-based model of accept, drop and replay.
module tb_imsic_setipnum_arbiter;

    localparam int NrReq       = 2;
    localparam int NrHarts     = 4;
    localparam int NrInptFiles = 3;
    localparam int NrSourcesW  = 6;
    localparam int FifoDepth   = 4;
    localparam int HartW       = 2;
    localparam int FileW       = 2;
    localparam int NrFiles     = NrHarts * NrInptFiles;
    localparam int SetW        = NrFiles * NrSourcesW;

    logic                        i_clk;
    logic                        ni_rst;
    logic [NrReq-1:0]            req_valid;
    logic [NrReq*HartW-1:0]      req_hart;
    logic [NrReq*FileW-1:0]      req_file;
    logic [NrReq*NrSourcesW-1:0] req_ip;
    logic                        stall;
    logic [NrReq-1:0]            o_req_ready;
    logic [SetW-1:0]             o_setipnum;
    logic [NrFiles-1:0]          o_setipnum_we;
    logic [15:0]                 o_drop_cnt;
    logic                        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue entries are flat_file * 2^NrSourcesW + ipnum.
    int q[$];
    int m_rr;
    int m_drop;
    int exp_g;

    logic [NrReq-1:0]   act_ready, exp_ready;
    logic [NrFiles-1:0] act_we, exp_we;
    logic [SetW-1:0]    act_set, exp_set;
    logic [15:0]        act_drop, exp_drop;
    logic               act_busy, exp_busy;

    imsic_setipnum_arbiter #(
        .NrReq(NrReq), .NrHarts(NrHarts), .NrInptFiles(NrInptFiles),
        .NrSourcesW(NrSourcesW), .FifoDepth(FifoDepth)
    ) dut (
        .i_clk(i_clk),
        .ni_rst(ni_rst),
        .i_req_valid(req_valid),
        .o_req_ready(o_req_ready),
        .i_req_hart(req_hart),
        .i_req_file(req_file),
        .i_req_ipnum(req_ip),
        .i_stall(stall),
        .o_setipnum(o_setipnum),
        .o_setipnum_we(o_setipnum_we),
        .o_drop_cnt(o_drop_cnt),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic set_req(input int r, input bit v, input int h, input int f, input int ip);
        req_valid[r]                        = v;
        req_hart[r*HartW +: HartW]          = HartW'(h);
        req_file[r*FileW +: FileW]          = FileW'(f);
        req_ip[r*NrSourcesW +: NrSourcesW]  = NrSourcesW'(ip);
    endtask

    task automatic do_reset();
        ni_rst    = 1'b0;
        req_valid = '0;
        req_hart  = '0;
        req_file  = '0;
        req_ip    = '0;
        stall     = 1'b0;
        q.delete();
        m_rr   = 0;
        m_drop = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        ni_rst = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    // One clock: sample ready mid-cycle, advance the model at the edge,
    // then sample the registered outputs just after it.
    task automatic cycle();
        int h, f, ip, e;
        #1;
        act_ready = o_req_ready;
        exp_ready = '0;
        exp_g     = -1;
        if (q.size() < FifoDepth) begin
            for (int k = 0; k < NrReq; k++) begin
                if (exp_g < 0 && req_valid[(m_rr + k) % NrReq]) exp_g = (m_rr + k) % NrReq;
            end
        end
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
        @(posedge i_clk);
        exp_we  = '0;
        exp_set = '0;
        if (q.size() != 0 && !stall) begin
            e = q.pop_front();
            exp_we[e / (1 << NrSourcesW)] = 1'b1;
            exp_set[(e / (1 << NrSourcesW)) * NrSourcesW +: NrSourcesW] =
                NrSourcesW'(e % (1 << NrSourcesW));
        end
        if (exp_g >= 0) begin
            h  = int'(req_hart[exp_g*HartW +: HartW]);
            f  = int'(req_file[exp_g*FileW +: FileW]);
            ip = int'(req_ip[exp_g*NrSourcesW +: NrSourcesW]);
            if (ip == 0 || h >= NrHarts || f >= NrInptFiles) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                q.push_back((h * NrInptFiles + f) * (1 << NrSourcesW) + ip);
            end
            m_rr = (exp_g + 1) % NrReq;
        end
        exp_drop = 16'(m_drop);
        exp_busy = (q.size() != 0) || (exp_we != '0);
        #1;
        act_we   = o_setipnum_we;
        act_set  = o_setipnum;
        act_drop = o_drop_cnt;
        act_busy = o_busy;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_setipnum !== '0 || o_setipnum_we !== '0 || o_drop_cnt !== 16'h0 ||
            o_busy !== 1'b0 || o_req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset: set=%h we=%h drop=%0d busy=%b ready=%b, required all zero",
                     o_setipnum, o_setipnum_we, o_drop_cnt, o_busy, o_req_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 1'b1, 2, 1, 5);
        cycle();
        n_checks++;
        if (act_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got %b required 01", act_ready);
        end
        req_valid = '0;
        cycle();
        n_checks++;
        if (act_we !== 12'h080 || act_set !== (SetW'(5) << (7 * NrSourcesW))) begin
            n_fail++;
            $display("FAIL single_strobe: we=%h set=%h required we=080 slice7=5", act_we, act_set);
        end
        cycle();
        n_checks++;
        if (act_we !== '0 || act_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: we=%h busy=%b required 0/0", act_we, act_busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 6) begin
                set_req(0, 1'b1, c % 4, c % 3, c + 1);
                set_req(1, 1'b1, (c + 1) % 4, (c + 2) % 3, c + 1);
            end else begin
                req_valid = '0;
            end
            cycle();
            if (c < 6) begin
                n_checks++;
                if (act_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: got %b required %b", c, act_ready,
                             (c % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            n_checks++;
            if ({act_ready, act_we, act_set, act_drop, act_busy} !==
                {exp_ready, exp_we, exp_set, exp_drop, exp_busy}) begin
                n_fail++;
                $display("FAIL rr_model[%0d]: ready=%b/%b we=%h/%h set=%h/%h drop=%0d/%0d busy=%b/%b (actual/required)",
                         c, act_ready, exp_ready, act_we, exp_we, act_set, exp_set,
                         act_drop, exp_drop, act_busy, exp_busy);
            end
        end
    endtask

    task automatic test_full_fifo();
        int offered;
        do_reset();
        offered = 0;
        stall   = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 6) stall = 1'b0;
            set_req(0, offered < 6, 1, 0, offered + 1);
            cycle();
            if (c == 4 || c == 6 || c == 7) begin
                n_checks++;
                if (act_ready !== ((c == 7) ? 2'b01 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL full_ready[%0d]: got %b required %b", c, act_ready,
                             (c == 7) ? 2'b01 : 2'b00);
                end
            end
            n_checks++;
            if ({act_ready, act_we, act_set, act_drop, act_busy} !==
                {exp_ready, exp_we, exp_set, exp_drop, exp_busy}) begin
                n_fail++;
                $display("FAIL full_model[%0d]: ready=%b/%b we=%h/%h set=%h/%h drop=%0d/%0d busy=%b/%b (actual/required)",
                         c, act_ready, exp_ready, act_we, exp_we, act_set, exp_set,
                         act_drop, exp_drop, act_busy, exp_busy);
            end
            if (exp_ready[0]) offered++;
        end
    endtask

    // hart >= NrHarts cannot be encoded with four harts in two bits, so the
    // third malformed case uses a zero identity from the other requester.
    task automatic test_malformed();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req_valid = '0;
            case (c)
                0: set_req(0, 1'b1, 1, 0, 0);
                1: set_req(1, 1'b1, 0, 3, 9);
                2: set_req(0, 1'b1, 3, 2, 0);
                5: set_req(1, 1'b1, 3, 2, 33);
                default: ;
            endcase
            cycle();
            if (c < 3) begin
                n_checks++;
                if (act_ready === 2'b00) begin
                    n_fail++;
                    $display("FAIL bad_accept[%0d]: ready=%b required a grant", c, act_ready);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (act_drop !== 16'd3 || act_we !== '0) begin
                    n_fail++;
                    $display("FAIL bad_drop: drop=%0d we=%h required 3/0", act_drop, act_we);
                end
            end
            n_checks++;
            if ({act_ready, act_we, act_set, act_drop, act_busy} !==
                {exp_ready, exp_we, exp_set, exp_drop, exp_busy}) begin
                n_fail++;
                $display("FAIL bad_model[%0d]: ready=%b/%b we=%h/%h set=%h/%h drop=%0d/%0d busy=%b/%b (actual/required)",
                         c, act_ready, exp_ready, act_we, exp_we, act_set, exp_set,
                         act_drop, exp_drop, act_busy, exp_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, c, c % 3, (c == 0) ? 0 : c + 10);
            cycle();
        end
        req_valid = '0;
        #2;
        ni_rst = 1'b0;
        #1;
        n_checks++;
        if (o_setipnum !== '0 || o_setipnum_we !== '0 || o_drop_cnt !== 16'h0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: set=%h we=%h drop=%0d busy=%b required all zero",
                     o_setipnum, o_setipnum_we, o_drop_cnt, o_busy);
        end
        q.delete();
        m_rr   = 0;
        m_drop = 0;
        stall  = 1'b0;
        @(negedge i_clk);
        ni_rst = 1'b1;
        @(posedge i_clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_checks++;
            if (act_we !== '0 || act_drop !== 16'h0 || act_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after[%0d]: we=%h drop=%0d busy=%b required 0/0/0",
                         c, act_we, act_drop, act_busy);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NrReq; r++) begin
                set_req(r, $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                        ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63));
            end
            stall = ($urandom_range(0, 3) == 0);
            cycle();
            n_checks++;
            if ({act_ready, act_we, act_set, act_drop, act_busy} !==
                {exp_ready, exp_we, exp_set, exp_drop, exp_busy}) begin
                n_fail++;
                $display("FAIL rand_model[%0d]: ready=%b/%b we=%h/%h set=%h/%h drop=%0d/%0d busy=%b/%b (actual/required)",
                         c, act_ready, exp_ready, act_we, exp_we, act_set, exp_set,
                         act_drop, exp_drop, act_busy, exp_busy);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_req(0, 1'b1, 1, 1, 0);
        for (int c = 1; c <= 65540; c++) begin
            cycle();
            if (c == 65534 || c == 65535 || c == 65540) begin
                n_checks++;
                if (act_drop !== exp_drop || act_drop !== ((c == 65534) ? 16'hFFFE : 16'hFFFF)) begin
                    n_fail++;
                    $display("FAIL sat_drop[%0d]: got %h required %h", c, act_drop, exp_drop);
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_fifo();
        test_malformed();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
